inport_buf: RTL and testbench
=============================

Name: inport_buf

Overview:
- Per-input-port stage of the 5-port router, sitting directly upstream of the five output-port mux controllers.
- Buffers incoming flits in a small FIFO and computes the XY output port from each head flit.
- Presents port/request to every output controller, holds the request for the whole packet, and pops flits as grants arrive.
- One instance per input port; its port_o/req_o feed the port_N/req_N inputs of each output controller.

Parameters:
- PORTID, 0, index of this input port; not used in logic, kept for instance identification.
- DEPTH, 4, FIFO depth in flits; power of two, minimum 2.
- FLITW, 34, flit width; [FLITW-1:FLITW-2] = type (01 head, 00 body, 10 tail, 11 single), head flit dst_x = [7:4], dst_y = [3:0].
- MYX, 0, router X coordinate (4 bits).
- MYY, 0, router Y coordinate (4 bits).

Ports:
- clk  input  1  clock
- rst_  input  1  synchronous active-low reset, sampled on posedge clk
- idata_i  input  FLITW  incoming flit
- ivalid_i  input  1  idata_i valid
- iready_o  output  1  FIFO can accept (= !full)
- odata_o  output  FLITW  FIFO front flit
- ovalid_o  output  1  odata_o valid for the current packet
- port_o  output  `PORTW+1  routed output port: 0 local, 1 north, 2 east, 3 south, 4 west
- req_o  output  1  request to output controllers
- grt_i  input  `PORT+1  bit k = grant for this input from output controller k
- err_o  output  1  one-cycle pulse when a stray non-head flit is dropped

Behaviour:
- Reset (rst_=0 at posedge): FIFO empty, pointers and count 0, state IDLE. Outputs: iready_o=1, ovalid_o=0, req_o=0, port_o=0, err_o=0. odata_o is don't-care. Reset mid-packet discards all buffered flits and releases req_o on the next cycle.
- FIFO:
  - Push when ivalid_i & iready_o.
  - iready_o = (count != DEPTH); no write-through when full.
  - Pop as defined by the FSM. Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- XY route, from the head flit dst fields:
  - dst_x > MYX → east (2); dst_x < MYX → west (4).
  - Otherwise dst_y > MYY → south (3); dst_y < MYY → north (1).
  - Otherwise local (0).
  - Comparisons are unsigned, 4 bits.
- FSM states IDLE, RC, ACTIVE:
  - IDLE: if the FIFO is non-empty and the front flit type is head or single → RC.
  - IDLE: if the FIFO is non-empty and the front flit is body or tail → pop it, pulse err_o, stay IDLE.
  - RC: register port_o from the front flit → ACTIVE. Latency: head pushed at cycle t gives req_o=1 at t+2.
  - ACTIVE: req_o=1 constantly, including cycles where the FIFO is empty, so the output controller keeps its hold. ovalid_o = !empty.
  - ACTIVE pop condition: ovalid_o & grt_i[port_o]. Grant bits for other ports are ignored.
  - ACTIVE exit: popping a flit of type tail or single → IDLE, and req_o drops the next cycle.
- Back-to-back packets: the next head always passes through IDLE (and RC), giving at least one req_o=0 cycle between packets so the output controller re-arbitrates.
- port_o is stable from RC until IDLE is re-entered.
- grt_i is ignored outside ACTIVE.

Optional Feature:
- Macro INBUF_LOOKAHEAD_EN.
- Defined: the RC state is removed. In IDLE the route is computed combinationally from the front head flit, port_o is registered on the same edge, and the FSM goes straight to ACTIVE. Head-to-req latency becomes t+1. The inter-packet req_o=0 gap remains one cycle.
- Undefined: three-state FSM as above, head-to-req latency t+2.

Test Plan:
- Reset, then a single flit (type 11, dst 2,0) at MYX=0, MYY=0 pushed at t=0 → port_o=2, req_o=1 at t=2; grt_i=5'b00100 at t=3 → pop; req_o=0 at t=4; iready_o=1 throughout.
- 4-flit packet (head, body, body, tail, dst 0,3 at MYX=0, MYY=1) with grt_i[3] toggling 1,0,1,1,1 → port_o=3, exactly 4 pops, req_o held high until the tail pop.
- DEPTH=4, push 5 flits with no grant → iready_o=0 after the 4th push, 5th not accepted, count stays 4; first pop → iready_o=1 the next cycle.
- Body flit arrives in IDLE → err_o pulses once, flit dropped, req_o stays 0; a following valid head routes normally.
- Mid-packet FIFO underrun (tail arrives 3 cycles late) → req_o stays 1, ovalid_o=0 during the gap, no pop while grant is held.
- Reset asserted in ACTIVE with 2 flits buffered → next cycle req_o=0, ovalid_o=0, count=0. With INBUF_LOOKAHEAD_EN, repeating the first scenario gives req_o=1 at t=1.

Source files
------------

// File: rtl/inport_buf.sv
// Input-port stage of the 5-port router: flit FIFO, XY route computation, request/grant handshake.
// Optional INBUF_LOOKAHEAD_EN: route in IDLE and skip the RC state (head-to-req latency of one cycle).
module inport_buf #(
    parameter int          PORTID = 0,
    parameter int          DEPTH  = 4,
    parameter int          FLITW  = 34,
    parameter logic [3:0]  MYX    = 4'd0,
    parameter logic [3:0]  MYY    = 4'd0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [FLITW-1:0] idata_i,
    input  logic             ivalid_i,
    output logic             iready_o,
    output logic [FLITW-1:0] odata_o,
    output logic             ovalid_o,
    output logic [2:0]       port_o,
    output logic             req_o,
    input  logic [4:0]       grt_i,
    output logic             err_o
);

    // state   | meaning
    // IDLE    | waiting for a head/single flit at the FIFO front; stray body/tail flits are dropped
    // RC      | route computation, port_o registered from the front head flit
    // ACTIVE  | req_o held for the whole packet, flits popped on grant until tail/single leaves

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RC     = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    // PORTID only tags the instance; nothing depends on it.
    if (PORTID < 0) begin : g_portid_tag
    end

    logic [FLITW-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    state_t           r_state;
    logic [2:0]       r_port;
    logic             r_req;
    logic             r_err;

    logic [FLITW-1:0] w_front;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_ovalid;
    logic             w_front_head;
    logic             w_front_last;
    logic [2:0]       w_route;

    function automatic logic [2:0] xy_route(input logic [3:0] dst_x, input logic [3:0] dst_y);
        logic [2:0] port;
        if (dst_x > MYX)      port = 3'd2;
        else if (dst_x < MYX) port = 3'd4;
        else if (dst_y > MYY) port = 3'd3;
        else if (dst_y < MYY) port = 3'd1;
        else                  port = 3'd0;
        return port;
    endfunction

    assign w_front      = r_mem[r_rd_ptr];
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_push       = ivalid_i && !w_full;
    assign w_ovalid     = (r_state == S_ACTIVE) && !w_empty;
    // type 01 head / 11 single carry routing info; 10 tail / 11 single close a packet
    assign w_front_head = w_front[FLITW-2];
    assign w_front_last = w_front[FLITW-1];
    assign w_route      = xy_route(w_front[7:4], w_front[3:0]);

    always_comb begin
        w_pop = 1'b0;
        unique case (r_state)
            S_IDLE:   w_pop = !w_empty && !w_front_head;
            S_ACTIVE: w_pop = w_ovalid && grt_i[r_port];
            default:  w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= idata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state <= S_IDLE;
            r_port  <= 3'd0;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        if (w_front_head) begin
`ifdef INBUF_LOOKAHEAD_EN
                            r_port  <= w_route;
                            r_req   <= 1'b1;
                            r_state <= S_ACTIVE;
`else
                            r_state <= S_RC;
`endif
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RC: begin
                    r_port  <= w_route;
                    r_req   <= 1'b1;
                    r_state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    // req drops only after the closing flit leaves, so the next head re-arbitrates
                    if (w_pop && w_front_last) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign iready_o = !w_full;
    assign odata_o  = w_front;
    assign ovalid_o = w_ovalid;
    assign port_o   = r_port;
    assign req_o    = r_req;
    assign err_o    = r_err;

endmodule

// File: tb/tb_inport_buf.sv
// Bench for inport_buf: directed scenarios plus random traffic, all checked against a queue-based model.
module tb_inport_buf;

    localparam int         DEPTH = 4;
    localparam int         FLITW = 34;
    localparam logic [3:0] MYX   = 4'd2;
    localparam logic [3:0] MYY   = 4'd1;
`ifdef INBUF_LOOKAHEAD_EN
    localparam int         LAT   = 1;
`else
    localparam int         LAT   = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_;
    logic [FLITW-1:0] idata_i;
    logic             ivalid_i;
    logic             iready_o;
    logic [FLITW-1:0] odata_o;
    logic             ovalid_o;
    logic [2:0]       port_o;
    logic             req_o;
    logic [4:0]       grt_i;
    logic             err_o;

    always #5 clk = ~clk;

    inport_buf #(
        .PORTID (0),
        .DEPTH  (DEPTH),
        .FLITW  (FLITW),
        .MYX    (MYX),
        .MYY    (MYY)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .idata_i  (idata_i),
        .ivalid_i (ivalid_i),
        .iready_o (iready_o),
        .odata_o  (odata_o),
        .ovalid_o (ovalid_o),
        .port_o   (port_o),
        .req_o    (req_o),
        .grt_i    (grt_i),
        .err_o    (err_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: buffered flits, whether a packet currently holds the request,
    // cycles left before the request rises, routed port and pending error pulse.
    logic [FLITW-1:0] m_q[$];
    bit               m_req;
    logic [2:0]       m_port;
    bit               m_err;
    int               m_wait;

    int dut_pops;
    int dut_pushes;
    int err_seen;

    function automatic logic [2:0] ref_route(input logic [FLITW-1:0] f);
        int dx;
        int dy;
        dx = int'(f[7:4]) - int'(MYX);
        dy = int'(f[3:0]) - int'(MYY);
        if (dx > 0) return 3'd2;
        if (dx < 0) return 3'd4;
        if (dy > 0) return 3'd3;
        if (dy < 0) return 3'd1;
        return 3'd0;
    endfunction

    function automatic logic [FLITW-1:0] mk_flit(input logic [1:0] t, input logic [3:0] x, input logic [3:0] y);
        logic [23:0] pl;
        pl = 24'($urandom());
        return {t, pl, x, y};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_req  = 1'b0;
        m_port = 3'd0;
        m_err  = 1'b0;
        m_wait = 0;
    endtask

    // Called at a negedge: drive inputs, compare outputs, advance model, move to the next negedge.
    task automatic step(input bit rn, input bit v, input logic [FLITW-1:0] d, input logic [4:0] g, output bit acc);
        bit         push;
        bit         pop;
        bit         nreq;
        bit         nerr;
        logic [2:0] nport;
        int         nwait;
        rst_     = rn;
        ivalid_i = v;
        idata_i  = d;
        grt_i    = g;
        #1;
        chk("iready", iready_o, 64'(m_q.size() < DEPTH));
        chk("req",    req_o,    64'(m_req));
        chk("ovalid", ovalid_o, 64'(m_req && m_q.size() > 0));
        chk("port",   port_o,   64'(m_port));
        chk("err",    err_o,    64'(m_err));
        if (m_req && m_q.size() > 0) chk("odata", odata_o, 64'(m_q[0]));
        if (iready_o && v) dut_pushes++;
        if (ovalid_o && g[port_o]) dut_pops++;
        if (err_o) err_seen++;

        push  = v && (m_q.size() < DEPTH);
        pop   = 1'b0;
        nerr  = 1'b0;
        nreq  = m_req;
        nport = m_port;
        nwait = m_wait;
        if (m_req) begin
            if (m_q.size() > 0 && g[m_port]) begin
                pop = 1'b1;
                if (m_q[0][FLITW-1]) nreq = 1'b0;
            end
        end else if (m_wait > 0) begin
            nwait = m_wait - 1;
            if (nwait == 0) begin
                nreq  = 1'b1;
                nport = ref_route(m_q[0]);
            end
        end else if (m_q.size() > 0) begin
            if (m_q[0][FLITW-2]) begin
                nwait = LAT - 1;
                if (nwait == 0) begin
                    nreq  = 1'b1;
                    nport = ref_route(m_q[0]);
                end
            end else begin
                pop  = 1'b1;
                nerr = 1'b1;
            end
        end

        if (!rn) begin
            model_reset();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(d);
            m_req  = nreq;
            m_port = nport;
            m_err  = nerr;
            m_wait = nwait;
        end
        acc = push && rn;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [4:0] g);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, g, acc);
    endtask

    task automatic send(input logic [FLITW-1:0] f, input logic [4:0] g);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1'b1, 1'b1, f, g, acc);
            tries++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [FLITW-1:0] pend[$];
        bit               acc;
        int               p0;
        int               e0;

        rst_     = 1'b0;
        ivalid_i = 1'b0;
        idata_i  = '0;
        grt_i    = '0;
        dut_pops = 0;
        dut_pushes = 0;
        err_seen = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_iready", iready_o, 1);
        chk("rst_req",    req_o,    0);
        chk("rst_ovalid", ovalid_o, 0);
        chk("rst_port",   port_o,   0);
        chk("rst_err",    err_o,    0);

        // single flit routed east, request latency and release
        step(1'b1, 1'b1, mk_flit(2'b11, 4'd4, 4'd1), 5'b0, acc);
        chk("s1_req_t0", req_o, 0);
        idle(1, 5'b0);
        chk("s1_req_t1", req_o, 64'(LAT == 1));
        idle(1, 5'b0);
        chk("s1_req_t2", req_o, 1);
        chk("s1_port", port_o, 2);
        idle(1, 5'b0);
        p0 = dut_pops;
        idle(1, 5'b00100);
        chk("s1_pops", dut_pops - p0, 1);
        chk("s1_req_t4", req_o, 0);
        chk("s1_iready", iready_o, 1);

        // 4-flit packet south with a toggling grant
        send(mk_flit(2'b01, 4'd2, 4'd3), 5'b0);
        send(mk_flit(2'b00, 4'd9, 4'd9), 5'b0);
        send(mk_flit(2'b00, 4'd7, 4'd1), 5'b0);
        send(mk_flit(2'b10, 4'd0, 4'd0), 5'b0);
        chk("s2_port", port_o, 3);
        chk("s2_req", req_o, 1);
        p0 = dut_pops;
        idle(1, 5'b01000);
        idle(1, 5'b00000);
        idle(1, 5'b01000);
        idle(1, 5'b01000);
        chk("s2_req_before_tail", req_o, 1);
        idle(1, 5'b01000);
        chk("s2_pops", dut_pops - p0, 4);
        chk("s2_req_after_tail", req_o, 0);
        idle(2, 5'b0);

        // overflow: five pushes into a depth-4 FIFO, local route
        p0 = dut_pushes;
        step(1'b1, 1'b1, mk_flit(2'b01, 4'd2, 4'd1), 5'b0, acc);
        step(1'b1, 1'b1, mk_flit(2'b00, 4'd3, 4'd3), 5'b0, acc);
        step(1'b1, 1'b1, mk_flit(2'b00, 4'd5, 4'd5), 5'b0, acc);
        step(1'b1, 1'b1, mk_flit(2'b10, 4'd6, 4'd6), 5'b0, acc);
        chk("s3_iready_full", iready_o, 0);
        step(1'b1, 1'b1, mk_flit(2'b00, 4'd1, 4'd1), 5'b0, acc);
        chk("s3_accepted", dut_pushes - p0, 4);
        chk("s3_port", port_o, 0);
        idle(1, 5'b00001);
        chk("s3_iready_after_pop", iready_o, 1);
        idle(4, 5'b00001);
        chk("s3_req_done", req_o, 0);

        // stray body in IDLE, then a valid single flit routed west
        e0 = err_seen;
        send(mk_flit(2'b00, 4'd3, 4'd3), 5'b11111);
        idle(4, 5'b11111);
        chk("s4_err_count", err_seen - e0, 1);
        chk("s4_req", req_o, 0);
        send(mk_flit(2'b11, 4'd0, 4'd1), 5'b0);
        idle(LAT, 5'b0);
        chk("s4_port", port_o, 4);
        chk("s4_req_after_head", req_o, 1);
        idle(2, 5'b10000);

        // underrun: tail arrives late while the grant is held
        send(mk_flit(2'b01, 4'd2, 4'd0), 5'b00010);
        send(mk_flit(2'b00, 4'd4, 4'd4), 5'b00010);
        idle(4, 5'b00010);
        p0 = dut_pops;
        for (int i = 0; i < 3; i++) begin
            chk("s5_gap_req", req_o, 1);
            chk("s5_gap_ovalid", ovalid_o, 0);
            idle(1, 5'b00010);
        end
        chk("s5_gap_pops", dut_pops - p0, 0);
        send(mk_flit(2'b10, 4'd1, 4'd1), 5'b00010);
        idle(3, 5'b00010);
        chk("s5_req_done", req_o, 0);

        // reset while ACTIVE with two flits buffered
        send(mk_flit(2'b01, 4'd5, 4'd1), 5'b0);
        send(mk_flit(2'b00, 4'd5, 4'd1), 5'b0);
        idle(3, 5'b0);
        chk("s6_req_before", req_o, 1);
        step(1'b0, 1'b0, '0, 5'b0, acc);
        chk("s6_req", req_o, 0);
        chk("s6_ovalid", ovalid_o, 0);
        chk("s6_iready", iready_o, 1);
        idle(3, 5'b11111);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            bit               v;
            bit               rn;
            logic [4:0]       g;
            logic [FLITW-1:0] d;
            if (pend.size() == 0) begin
                int len;
                logic [3:0] x;
                logic [3:0] y;
                x = 4'($urandom_range(0, 4));
                y = 4'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) begin
                    pend.push_back(mk_flit($urandom_range(0, 1) ? 2'b00 : 2'b10, x, y));
                end else begin
                    len = $urandom_range(1, 5);
                    if (len == 1) begin
                        pend.push_back(mk_flit(2'b11, x, y));
                    end else begin
                        pend.push_back(mk_flit(2'b01, x, y));
                        for (int k = 0; k < len - 2; k++) pend.push_back(mk_flit(2'b00, x, y));
                        pend.push_back(mk_flit(2'b10, x, y));
                    end
                end
            end
            v  = (pend.size() > 0) && ($urandom_range(0, 9) < 7);
            d  = v ? pend[0] : '0;
            g  = 5'($urandom());
            if ($urandom_range(0, 1) == 1) g[m_port] = 1'b1;
            rn = ($urandom_range(0, 599) != 0);
            step(rn, v, d, g, acc);
            if (acc) void'(pend.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
